// File: rtl/adc_spi_sampler.sv
// SPI sampler for a two-channel ADC: reads a side/diagonal sample pair every SAMPLE_PERIOD clocks.
// Optional build macro ADC_AVG_EN: each output becomes the floor average of its previous value and the new sample.
module adc_spi_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [15:0] side_adc_data,
    output logic [15:0] diag_adc_data,
    output logic        data_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CS_GAP,
        WAIT
    } state_t;

    localparam int            PW          = $clog2(SAMPLE_PERIOD) + 1;
    localparam logic [7:0]    DIV_LAST    = 8'(CLK_DIV - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [PW-1:0] PERIOD_ONE  = PW'(1);

    state_t        state_q, state_d;
    logic [7:0]    divCnt_q, divCnt_d;
    logic [3:0]    bitCnt_q, bitCnt_d;
    logic [PW-1:0] period_q, period_d;
    logic          chan_q, chan_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          csN_q, csN_d;
    logic          valid_q, valid_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   sideRaw_q, sideRaw_d;
    logic [15:0]   sideOut_q, sideOut_d;
    logic [15:0]   diagOut_q, diagOut_d;
    logic [15:0]   cmdWord;
    logic          divDone;

`ifdef ADC_AVG_EN
    logic havePrev_q, havePrev_d;

    // Floor average: 17-bit signed sum so the carry is kept, then arithmetic shift.
    function automatic logic [15:0] avg16(input logic [15:0] prev, input logic [15:0] sample);
        logic signed [16:0] total;
        total = $signed({prev[15], prev}) + $signed({sample[15], sample});
        total = total >>> 1;
        return total[15:0];
    endfunction
`endif

    assign cmdWord = {1'b1, 2'b00, chan_q, 12'h000};
    assign divDone = (divCnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        divCnt_d  = divCnt_q + 8'd1;
        bitCnt_d  = bitCnt_q;
        period_d  = period_q + PERIOD_ONE;
        chan_d    = chan_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        valid_d   = 1'b0;
        shift_d   = shift_q;
        sideRaw_d = sideRaw_q;
        sideOut_d = sideOut_q;
        diagOut_d = diagOut_q;
`ifdef ADC_AVG_EN
        havePrev_d = havePrev_q;
`endif

        case (state_q)
            IDLE: begin
                divCnt_d = 8'd0;
                period_d = '0;
                sclk_d   = 1'b0;
                mosi_d   = 1'b0;
                if (enable) begin
                    state_d  = CS_SETUP;
                    chan_d   = 1'b0;
                    bitCnt_d = 4'd0;
                    mosi_d   = 1'b1;
                end
            end
            CS_SETUP: begin
                if (divDone) begin
                    state_d  = SHIFT;
                    divCnt_d = 8'd0;
                    bitCnt_d = 4'd0;
                end
            end
            SHIFT: begin
                // Rising SCLK edge captures MISO; falling edge advances MOSI or ends the frame.
                if (divDone) begin
                    divCnt_d = 8'd0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[14:0], spi_miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bitCnt_q == 4'd15) begin
                            state_d  = CS_HOLD;
                            bitCnt_d = 4'd0;
                            mosi_d   = 1'b0;
                        end else begin
                            bitCnt_d = bitCnt_q + 4'd1;
                            mosi_d   = cmdWord[4'd14 - bitCnt_q];
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (divDone) begin
                    state_d  = CS_GAP;
                    divCnt_d = 8'd0;
                end
            end
            CS_GAP: begin
                if (divDone) begin
                    divCnt_d = 8'd0;
                    if (!chan_q) begin
                        state_d   = CS_SETUP;
                        chan_d    = 1'b1;
                        mosi_d    = 1'b1;
                        sideRaw_d = shift_q;
                    end else begin
                        state_d = WAIT;
                        chan_d  = 1'b0;
                        valid_d = 1'b1;
`ifdef ADC_AVG_EN
                        sideOut_d  = havePrev_q ? avg16(sideOut_q, sideRaw_q) : sideRaw_q;
                        diagOut_d  = havePrev_q ? avg16(diagOut_q, shift_q) : shift_q;
                        havePrev_d = 1'b1;
`else
                        sideOut_d = sideRaw_q;
                        diagOut_d = shift_q;
`endif
                    end
                end
            end
            WAIT: begin
                divCnt_d = 8'd0;
                if (period_q >= PERIOD_LAST) begin
                    if (enable) begin
                        state_d  = CS_SETUP;
                        period_d = '0;
                        mosi_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        csN_d = !(state_d inside {CS_SETUP, SHIFT, CS_HOLD});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            divCnt_q  <= 8'd0;
            bitCnt_q  <= 4'd0;
            period_q  <= '0;
            chan_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            csN_q     <= 1'b1;
            valid_q   <= 1'b0;
            shift_q   <= 16'h0000;
            sideRaw_q <= 16'h0000;
            sideOut_q <= 16'h0000;
            diagOut_q <= 16'h0000;
`ifdef ADC_AVG_EN
            havePrev_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            divCnt_q  <= divCnt_d;
            bitCnt_q  <= bitCnt_d;
            period_q  <= period_d;
            chan_q    <= chan_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            csN_q     <= csN_d;
            valid_q   <= valid_d;
            shift_q   <= shift_d;
            sideRaw_q <= sideRaw_d;
            sideOut_q <= sideOut_d;
            diagOut_q <= diagOut_d;
`ifdef ADC_AVG_EN
            havePrev_q <= havePrev_d;
`endif
        end
    end

    assign spi_sclk      = sclk_q;
    assign spi_cs_n      = csN_q;
    assign spi_mosi      = mosi_q;
    assign data_valid    = valid_q;
    assign side_adc_data = sideOut_q;
    assign diag_adc_data = diagOut_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Testbench for adc_spi_sampler: two instances (default timing and CLK_DIV=2) each talking to a small ADC model.
// Expected outputs come from a pair-level model that also covers the ADC_AVG_EN build.
module tb_adc_spi_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enableA, enableB;
    logic        sclkA, csA, mosiA, misoA, dvA, busyA;
    logic        sclkB, csB, mosiB, misoB, dvB, busyB;
    logic [15:0] sideA, diagA, sideB, diagB;

    int assertCount = 0;
    int failCount   = 0;

    logic [15:0] sideWordA = 16'h0, diagWordA = 16'h0, txA = 16'h0, cmdShA = 16'h0;
    logic [15:0] sideWordB = 16'h0, diagWordB = 16'h0, txB = 16'h0, cmdShB = 16'h0;
    bit          parityA = 1'b0, parityB = 1'b0;
    logic [15:0] cmdQA[$];
    logic [15:0] cmdQB[$];
    logic [15:0] expSideA = 16'h0, expDiagA = 16'h0, expSideB = 16'h0, expDiagB = 16'h0;
`ifdef ADC_AVG_EN
    bit freshA = 1'b1, freshB = 1'b1;
`endif

    adc_spi_sampler dutA (
        .clk(clk), .reset(reset), .enable(enableA),
        .spi_sclk(sclkA), .spi_cs_n(csA), .spi_mosi(mosiA), .spi_miso(misoA),
        .side_adc_data(sideA), .diag_adc_data(diagA), .data_valid(dvA), .busy(busyA)
    );

    adc_spi_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(200)) dutB (
        .clk(clk), .reset(reset), .enable(enableB),
        .spi_sclk(sclkB), .spi_cs_n(csB), .spi_mosi(mosiB), .spi_miso(misoB),
        .side_adc_data(sideB), .diag_adc_data(diagB), .data_valid(dvB), .busy(busyB)
    );

    always #5 clk = ~clk;

    // ADC model: loads the frame's word when CS falls, shifts on SCLK fall; frames alternate side/diag.
    always @(negedge csA) begin txA = parityA ? diagWordA : sideWordA; misoA = txA[15]; end
    always @(negedge sclkA) if (!csA) begin txA = {txA[14:0], 1'b0}; misoA = txA[15]; end
    always @(posedge csA) begin parityA = ~parityA; cmdQA.push_back(cmdShA); end
    always @(posedge sclkA) cmdShA = {cmdShA[14:0], mosiA};

    always @(negedge csB) begin txB = parityB ? diagWordB : sideWordB; misoB = txB[15]; end
    always @(negedge sclkB) if (!csB) begin txB = {txB[14:0], 1'b0}; misoB = txB[15]; end
    always @(posedge csB) begin parityB = ~parityB; cmdQB.push_back(cmdShB); end
    always @(posedge sclkB) cmdShB = {cmdShB[14:0], mosiB};

`ifdef ADC_AVG_EN
    function automatic logic [15:0] blend(input logic [15:0] prev, input logic [15:0] raw, input bit fresh);
        logic signed [31:0] total;
        total = $signed({{16{prev[15]}}, prev}) + $signed({{16{raw[15]}}, raw});
        total = total >>> 1;
        return fresh ? raw : total[15:0];
    endfunction
`endif

    task automatic modelPair(input bit toB);
`ifdef ADC_AVG_EN
        if (toB) begin
            expSideB = blend(expSideB, sideWordB, freshB);
            expDiagB = blend(expDiagB, diagWordB, freshB);
            freshB = 1'b0;
        end else begin
            expSideA = blend(expSideA, sideWordA, freshA);
            expDiagA = blend(expDiagA, diagWordA, freshA);
            freshA = 1'b0;
        end
`else
        if (toB) begin
            expSideB = sideWordB;
            expDiagB = diagWordB;
        end else begin
            expSideA = sideWordA;
            expDiagA = diagWordA;
        end
`endif
    endtask

    task automatic modelReset();
        expSideA = 16'h0; expDiagA = 16'h0; expSideB = 16'h0; expDiagB = 16'h0;
`ifdef ADC_AVG_EN
        freshA = 1'b1; freshB = 1'b1;
`endif
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit toB, input logic [15:0] s, input logic [15:0] d);
        if (toB) begin sideWordB = s; diagWordB = d; end
        else begin sideWordA = s; diagWordA = d; end
    endtask

    task automatic waitValidA(input int budget, input int dropAt, output int cycles, output int busyLows);
        cycles = 0;
        busyLows = 0;
        while (cycles < budget) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == dropAt) enableA = 1'b0;
            if (!busyA) busyLows++;
            if (dvA) break;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".cs_n"}, csA, 1);
        checkOutput({tag, ".sclk"}, sclkA, 0);
        checkOutput({tag, ".mosi"}, mosiA, 0);
        checkOutput({tag, ".valid"}, dvA, 0);
        checkOutput({tag, ".busy"}, busyA, 0);
        checkOutput({tag, ".side"}, sideA, 0);
        checkOutput({tag, ".diag"}, diagA, 0);
    endtask

    task automatic checkCommands(input string tag);
        checkOutput({tag, ".cmdCount"}, cmdQA.size(), 2);
        checkOutput({tag, ".cmdSide"}, (cmdQA.size() > 0) ? cmdQA[0] : 16'hxxxx, 16'h8000);
        checkOutput({tag, ".cmdDiag"}, (cmdQA.size() > 1) ? cmdQA[1] : 16'hxxxx, 16'h9000);
    endtask

    initial begin
        int n, busyLows, dvCount, csLowCount, firstRise, secondRise;
        logic prevSclk;
        logic [15:0] rs, rd;

        reset = 1'b1; enableA = 1'b0; enableB = 1'b0; misoA = 1'b0; misoB = 1'b0;
        #1;
        checkResetState("powerOnReset");
        checkOutput("powerOnReset.csB", csB, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        parityA = 1'b0; parityB = 1'b0;
        cmdQA.delete(); cmdQB.delete();
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("idleWithoutEnable.busy", busyA, 0);

        // Known pair: latency to the strobe and the command words on MOSI.
        applyStimulus(1'b0, 16'h1234, 16'hF000);
        enableA = 1'b1;
        waitValidA(400, -1, n, busyLows);
        modelPair(1'b0);
        checkOutput("firstPair.validCycle", n, 281);
        checkOutput("firstPair.busyLows", busyLows, 0);
        checkOutput("firstPair.side", sideA, expSideA);
        checkOutput("firstPair.diag", diagA, expDiagA);
        checkCommands("firstPair");

        // Continuous sampling with random ADC words.
        for (int p = 0; p < 3; p++) begin
            rs = 16'($urandom);
            rd = 16'($urandom);
            applyStimulus(1'b0, rs, rd);
            @(posedge clk);
            @(negedge clk);
            checkOutput("continuous.validWidth", dvA, 0);
            checkOutput("continuous.busyAfterValid", busyA, 1);
            waitValidA(1100, -1, n, busyLows);
            modelPair(1'b0);
            checkOutput("continuous.validSpacing", n + 1, 1000);
            checkOutput("continuous.busyLows", busyLows, 0);
            checkOutput("continuous.side", sideA, expSideA);
            checkOutput("continuous.diag", diagA, expDiagA);
        end

        // Enable dropped while waiting: the period runs out, then back to idle.
        enableA = 1'b0;
        n = 0;
        while (busyA && n < 1100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checkOutput("waitToIdle.cycles", n, 720);

        // Enable dropped mid-pair: pair still completes with exactly one strobe.
        applyStimulus(1'b0, 16'($urandom), 16'($urandom));
        cmdQA.delete();
        enableA = 1'b1;
        waitValidA(400, 50, n, busyLows);
        modelPair(1'b0);
        checkOutput("earlyDrop.validCycle", n, 281);
        checkOutput("earlyDrop.side", sideA, expSideA);
        checkOutput("earlyDrop.diag", diagA, expDiagA);
        checkCommands("earlyDrop");
        dvCount = 0;
        csLowCount = 0;
        for (int c = 0; c < 1100; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (dvA) dvCount++;
            if (!csA) csLowCount++;
        end
        checkOutput("earlyDrop.extraValids", dvCount, 0);
        checkOutput("earlyDrop.csLowAfter", csLowCount, 0);
        checkOutput("earlyDrop.idle", busyA, 0);

        // Reset in the middle of the diag frame.
        applyStimulus(1'b0, 16'($urandom), 16'($urandom));
        enableA = 1'b1;
        repeat (200) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("midDiag.csLow", csA, 0);
        reset = 1'b1;
        enableA = 1'b0;
        #1;
        checkResetState("midDiagReset");
        parityA = 1'b0;
        cmdQA.delete();
        modelReset();
        dvCount = 0;
        repeat (3) begin
            @(negedge clk);
            if (dvA) dvCount++;
        end
        checkOutput("midDiagReset.noValid", dvCount, 0);
        rs = 16'($urandom);
        rd = 16'($urandom);
        applyStimulus(1'b0, rs, rd);
        reset = 1'b0;
        enableA = 1'b1;
        waitValidA(400, -1, n, busyLows);
        modelPair(1'b0);
        checkOutput("afterReset.validCycle", n, 281);
        checkOutput("afterReset.side", sideA, expSideA);
        checkOutput("afterReset.diag", diagA, expDiagA);
        checkCommands("afterReset");
        enableA = 1'b0;

        // Fast instance: SCLK period, frame length and bit-exact capture.
        applyStimulus(1'b1, 16'hA5C3, 16'($urandom));
        cmdQB.delete();
        enableB = 1'b1;
        n = 0; csLowCount = 0; firstRise = 0; secondRise = 0; prevSclk = 1'b0;
        while (n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (sclkB && !prevSclk) begin
                if (firstRise == 0) firstRise = n;
                else if (secondRise == 0) secondRise = n;
            end
            prevSclk = sclkB;
            if (!csB) csLowCount++;
            if (dvB) break;
        end
        modelPair(1'b1);
        checkOutput("fastDiv.validCycle", n, 141);
        checkOutput("fastDiv.firstRise", firstRise, 5);
        checkOutput("fastDiv.sclkPeriod", secondRise - firstRise, 4);
        checkOutput("fastDiv.csLowCycles", csLowCount, 136);
        checkOutput("fastDiv.side", sideB, expSideB);
        checkOutput("fastDiv.diag", diagB, expDiagB);
        checkOutput("fastDiv.cmdCount", cmdQB.size(), 2);
        checkOutput("fastDiv.cmdDiag", (cmdQB.size() > 1) ? cmdQB[1] : 16'hxxxx, 16'h9000);
        enableB = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
